// File: rtl/clock_pkg.sv
// clock_pkg: field limits, widths and month-length lookup shared by the clock datapath
package clock_pkg;

    localparam int SEC_MAX   = 59;
    localparam int MIN_MAX   = 59;
    localparam int HOUR_MAX  = 23;
    localparam int DAY_MIN   = 1;
    localparam int MONTH_MAX = 12;

    localparam int SEC_W  = 6;
    localparam int HOUR_W = 5;
    localparam int YEAR_W = 14;

    localparam logic [4:0] DAYS_IN_MONTH [1:12] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    // February gains a day in leap years; out-of-range months fall back to 31
    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
        if (month < 4'd1 || month > 4'd12) return 5'd31;
        return (month == 4'd2 && leap) ? 5'd29 : DAYS_IN_MONTH[month];
    endfunction

endpackage

// File: rtl/edge_rise.sv
// edge_rise: registered 1-bit rising-edge detector with selectable reset value
module edge_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic q;

    // track the input every cycle; reset to RST_VAL so a level held through reset is not an edge
    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

    assign rise = d & ~q;

endmodule

// File: rtl/mod_counter.sv
// mod_counter: modulo up/down counter with set-mode stepping and wrap carry for chained clock fields
module mod_counter
    import clock_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int MIN_VAL     = 0,
    parameter int DEFAULT_MAX = 59,
    parameter int RESET_VAL   = 0,
    parameter int DYN_MAX     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             adjust,
    input  logic             up,
    input  logic             down,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] value,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] MIN_V     = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] DEF_MAX_V = WIDTH'(DEFAULT_MAX);
    localparam logic [WIDTH-1:0] RST_V     = WIDTH'(RESET_VAL);

    if (RESET_VAL < MIN_VAL || RESET_VAL > DEFAULT_MAX || (DEFAULT_MAX >> WIDTH) != 0) begin : g_bad_params
        $error("mod_counter: RESET_VAL outside [MIN_VAL, DEFAULT_MAX] or DEFAULT_MAX does not fit WIDTH");
    end

    logic             up_rise, down_rise;
    logic [WIDTH-1:0] cur_max, next_value;
    logic             next_carry, at_max, at_min;

    edge_rise #(.RST_VAL(1'b1)) u_up_edge   (.clk(clk), .rst(rst), .d(up),   .rise(up_rise));
    edge_rise #(.RST_VAL(1'b1)) u_down_edge (.clk(clk), .rst(rst), .d(down), .rise(down_rise));

    assign cur_max = (DYN_MAX != 0) ? max_val : DEF_MAX_V;
    assign at_max  = value == cur_max;
    assign at_min  = value == MIN_V;

    // next value by priority: clamp, set-mode step, count tick, hold
    always_comb begin
        next_value = value;
        next_carry = 1'b0;
        if (value > cur_max) begin
            next_value = cur_max;
        end else if (adjust) begin
            if (up_rise && !down_rise)      next_value = at_max ? MIN_V : value + 1'b1;
            else if (down_rise && !up_rise) next_value = at_min ? cur_max : value - 1'b1;
        end else if (tick) begin
            next_value = at_max ? MIN_V : value + 1'b1;
            next_carry = at_max;
        end
    end

    // single register stage for value and carry
    always_ff @(posedge clk) begin
        if (rst) begin
            value     <= RST_V;
            carry_out <= 1'b0;
        end else begin
            value     <= next_value;
            carry_out <= next_carry;
        end
    end

endmodule
